// File: rtl/l1_cache_responder.sv
// -----------------------------------------------------------------------------
// l1_cache_responder
//
// Direct-mapped, write-back cache. It answers the processor's 16-bit memory
// port and issues 128-bit line fills and writebacks to physical memory. Line
// fills and writebacks stay hidden behind the processor's hold-until-resp
// handshake.
//
// Optional feature macro: CACHE_PERF_COUNTERS_EN
//   When defined, adds the saturating 16-bit outputs hit_count and miss_count.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   mem_read/mem_write    processor request, held until mem_resp
//   mem_byte_enable[1:0]  write byte mask (bit0 = low byte)
//   mem_address[15:0]     byte address (bit 0 ignored)
//   mem_wdata[15:0]       write data
//   mem_resp              one-cycle completion pulse
//   mem_rdata[15:0]       read data, valid while mem_resp = 1
//   pmem_read/pmem_write  line fill / writeback request, held until pmem_resp
//   pmem_address[15:0]    line address, low nibble always 0
//   pmem_wdata[127:0]     line being written back
//   pmem_resp             physical memory completion pulse
//   pmem_rdata[127:0]     fill data, valid with pmem_resp
//   hit_count/miss_count  (CACHE_PERF_COUNTERS_EN only) IDLE hit/miss counts
// -----------------------------------------------------------------------------
module l1_cache_responder #(
    parameter int INDEX_BITS = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [1:0]   mem_byte_enable,
    input  logic [15:0]  mem_address,
    input  logic [15:0]  mem_wdata,
    output logic         mem_resp,
    output logic [15:0]  mem_rdata,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic         pmem_resp,
    input  logic [127:0] pmem_rdata
`ifdef CACHE_PERF_COUNTERS_EN
    ,
    output logic [15:0]  hit_count,
    output logic [15:0]  miss_count
`endif
);

    localparam int SETS     = 1 << INDEX_BITS;
    localparam int TAG_BITS = 12 - INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE,
        RESP,
        WRITEBACK,
        FILL
    } state_t;

    state_t state_reg, state_next;

    // Status bits need a reset; tags and line data do not, since an invalid
    // set is never looked at.
    logic [SETS-1:0]     valid_reg;
    logic [SETS-1:0]     dirty_reg;
    logic [TAG_BITS-1:0] tag_arr  [SETS];
    logic [127:0]        line_arr [SETS];

    logic [15:0] rdata_reg;
    // {tag, index} of the missing request. It is captured at the miss so that
    // pmem_address stays stable for the whole fill/writeback.
    logic [11:0] miss_line_reg;

    logic [INDEX_BITS-1:0] cur_index;
    logic [INDEX_BITS-1:0] miss_index;
    logic [TAG_BITS-1:0]   cur_tag;
    logic [TAG_BITS-1:0]   miss_tag;
    logic [2:0]            cur_word;
    logic [127:0]          cur_line;
    logic [127:0]          merged_line;
    logic [15:0]           cur_word_data;
    logic                  req_active;
    logic                  hit;
    logic                  hit_event;
    logic                  miss_event;
    logic                  wb_done;
    logic                  fill_done;
    logic                  unused_addr_bit;

    assign cur_index       = mem_address[INDEX_BITS+3:4];
    assign cur_tag         = mem_address[15:INDEX_BITS+4];
    assign cur_word        = mem_address[3:1];
    assign unused_addr_bit = mem_address[0];
    assign miss_index      = miss_line_reg[INDEX_BITS-1:0];
    assign miss_tag        = miss_line_reg[11:INDEX_BITS];

    assign cur_line      = line_arr[cur_index];
    assign cur_word_data = cur_line[{cur_word, 4'b0000} +: 16];
    assign req_active    = mem_read | mem_write;
    assign hit           = valid_reg[cur_index] && (tag_arr[cur_index] == cur_tag);

    assign hit_event  = (state_reg == IDLE) && req_active && hit;
    assign miss_event = (state_reg == IDLE) && req_active && !hit;
    assign wb_done    = (state_reg == WRITEBACK) && pmem_resp;
    assign fill_done  = (state_reg == FILL) && pmem_resp;

    // Byte merge of write data into the addressed word. Every other word
    // passes through unchanged.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_merge
            logic word_sel;
            assign word_sel = (cur_word == 3'(gi));
            assign merged_line[16*gi +: 8] =
                (word_sel && mem_byte_enable[0]) ? mem_wdata[7:0] : cur_line[16*gi +: 8];
            assign merged_line[16*gi+8 +: 8] =
                (word_sel && mem_byte_enable[1]) ? mem_wdata[15:8] : cur_line[16*gi+8 +: 8];
        end
    endgenerate

    // Next state and outputs. The pmem outputs depend only on state and
    // registered data, so reset forces them to zero at once.
    always_comb begin
        state_next   = state_reg;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 16'h0000;
        pmem_wdata   = 128'h0;
        case (state_reg)
            IDLE: begin
                if (req_active) begin
                    if (hit) begin
                        state_next = RESP;
                    end else if (valid_reg[cur_index] && dirty_reg[cur_index]) begin
                        state_next = WRITEBACK;
                    end else begin
                        state_next = FILL;
                    end
                end
            end
            RESP: begin
                mem_resp   = 1'b1;
                state_next = IDLE;
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_arr[miss_index], miss_index, 4'b0000};
                pmem_wdata   = line_arr[miss_index];
                if (pmem_resp) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {miss_tag, miss_index, 4'b0000};
                if (pmem_resp) begin
                    // Go back to IDLE so that the held request is retried as a hit.
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign mem_rdata = rdata_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            valid_reg     <= '0;
            dirty_reg     <= '0;
            rdata_reg     <= 16'h0000;
            miss_line_reg <= 12'h000;
        end else begin
            state_reg <= state_next;
            if (hit_event) begin
                // A write takes priority when read and write are both high.
                // An all-zero mask still marks the line dirty.
                if (mem_write) begin
                    dirty_reg[cur_index] <= 1'b1;
                end else begin
                    rdata_reg <= cur_word_data;
                end
            end
            if (miss_event) begin
                miss_line_reg <= mem_address[15:4];
            end
            if (wb_done) begin
                dirty_reg[miss_index] <= 1'b0;
            end
            if (fill_done) begin
                valid_reg[miss_index] <= 1'b1;
                dirty_reg[miss_index] <= 1'b0;
            end
        end
    end

    // Tag and line storage
    always_ff @(posedge clk) begin
        if (hit_event && mem_write) begin
            line_arr[cur_index] <= merged_line;
        end
        if (fill_done) begin
            line_arr[miss_index] <= pmem_rdata;
            tag_arr[miss_index]  <= miss_tag;
        end
    end

`ifdef CACHE_PERF_COUNTERS_EN
    // Saturating counters. A miss is also counted as a hit later, when the
    // request is retried after the fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= 16'h0000;
            miss_count <= 16'h0000;
        end else begin
            if (hit_event && (hit_count != 16'hFFFF)) begin
                hit_count <= hit_count + 16'd1;
            end
            if (miss_event && (miss_count != 16'hFFFF)) begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_l1_cache_responder.sv
// -----------------------------------------------------------------------------
// tb_l1_cache_responder
//
// Scoreboard bench for l1_cache_responder. The driver uses a word-level
// reference memory and a per-set residency table to build the expected
// response and the expected pmem traffic for each request, and it queues
// them. The monitor pops and compares an entry on every mem_resp. The pmem
// responder models physical memory and checks the handshake rules.
// -----------------------------------------------------------------------------
module tb_l1_cache_responder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         mem_read;
    logic         mem_write;
    logic [1:0]   mem_byte_enable;
    logic [15:0]  mem_address;
    logic [15:0]  mem_wdata;
    logic         mem_resp;
    logic [15:0]  mem_rdata;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic         pmem_resp;
    logic [127:0] pmem_rdata;
`ifdef CACHE_PERF_COUNTERS_EN
    logic [15:0]  hit_count;
    logic [15:0]  miss_count;
`endif

    l1_cache_responder #(.INDEX_BITS(3)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_resp        (mem_resp),
        .mem_rdata       (mem_rdata),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_address    (pmem_address),
        .pmem_wdata      (pmem_wdata),
        .pmem_resp       (pmem_resp),
        .pmem_rdata      (pmem_rdata)
`ifdef CACHE_PERF_COUNTERS_EN
        ,
        .hit_count       (hit_count),
        .miss_count      (miss_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [15:0] addr;
        bit          is_read;
        logic [15:0] data;
        int          fills;
        int          wbs;
        bit          hit;
        int          issue_cyc;
    } exp_t;

    exp_t sbq[$];

    int errors = 0;
    int checks = 0;

    // Physical memory. base_mem holds preloaded lines and pmem_mem holds
    // the lines the DUT wrote back.
    logic [127:0] base_mem [int];
    logic [127:0] pmem_mem [int];
    int           resp_delay = 1;
    int           fill_cnt = 0;
    int           wb_cnt = 0;
    int           last_hold = 0;
    logic [15:0]  last_fill_addr = 16'hFFFF;
    logic [15:0]  last_wb_addr = 16'hFFFF;
    logic [127:0] last_wb_data = '0;
    logic [15:0]  last_rdata = 16'h0000;

    // Reference model. shadow is the architectural word value. committed
    // holds the words that were written back and so survive a reset.
    logic [15:0] shadow    [int];
    logic [15:0] committed [int];
    bit          res_valid [8];
    bit          res_dirty [8];
    int          res_tag   [8];
    int          model_hits = 0;
    int          model_misses = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] base_line(int la);
        logic [127:0] l;
        if (base_mem.exists(la)) return base_mem[la];
        for (int w = 0; w < 8; w++) begin
            l[16*w +: 16] = 16'((la * 37) ^ (w * 4369) ^ 32'h3C5A);
        end
        return l;
    endfunction

    function automatic logic [15:0] model_word(int wa);
        logic [127:0] l;
        if (shadow.exists(wa)) return shadow[wa];
        l = base_line(wa & 32'hFFF0);
        return l[16*((wa >> 1) & 7) +: 16];
    endfunction

    task automatic print_summary();
        $display("Result: errors=%0d of %0d checks", errors, checks);
    endtask

    // Works out the expected outcome from the model, queues it, then runs one
    // handshake. Call it just after a negedge.
    task automatic do_txn(input bit rd, input bit wr, input logic [1:0] be,
                          input logic [15:0] addr, input logic [15:0] wd);
        exp_t        e;
        int          set;
        int          tag;
        int          wa;
        int          base;
        logic [15:0] old;
        bit          got;
        set  = (int'(addr) >> 4) & 7;
        tag  = int'(addr) >> 7;
        wa   = int'(addr) & 32'hFFFE;
        e.addr  = addr;
        e.hit   = res_valid[set] && (res_tag[set] == tag);
        e.fills = e.hit ? 0 : 1;
        e.wbs   = (!e.hit && res_valid[set] && res_dirty[set]) ? 1 : 0;
        if (e.wbs == 1) begin
            base = (res_tag[set] << 7) | (set << 4);
            for (int w = 0; w < 8; w++) committed[base + 2*w] = model_word(base + 2*w);
        end
        e.is_read = !wr;
        e.data    = 16'h0000;
        if (wr) begin
            old = model_word(wa);
            shadow[wa] = {be[1] ? wd[15:8] : old[15:8], be[0] ? wd[7:0] : old[7:0]};
        end else begin
            e.data = model_word(wa);
        end
        res_dirty[set] = wr ? 1'b1 : (e.hit ? res_dirty[set] : 1'b0);
        res_valid[set] = 1'b1;
        res_tag[set]   = tag;
        // After a fill the retried request counts as a hit too.
        model_hits++;
        if (!e.hit) model_misses++;
        e.issue_cyc = cyc;
        sbq.push_back(e);

        mem_read        = rd;
        mem_write       = wr;
        mem_byte_enable = be;
        mem_address     = addr;
        mem_wdata       = wd;
        got = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (mem_resp) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            errors++;
            checks++;
            $display("FAIL resp_timeout: addr=%h got no mem_resp, required one within 500 cycles", addr);
            print_summary();
            $finish;
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
    endtask

    // Physical memory responder, sampled on negedges.
    logic [15:0]  held_addr;
    logic [127:0] held_wdata;
    logic         held_rd;
    int           hold = 0;
    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (pmem_resp) begin
                pmem_resp = 1'b0;
                hold = 0;
            end else if (!rst_n || !(pmem_read || pmem_write)) begin
                hold = 0;
            end else begin
                check("pmem_rd_wr_exclusive", 128'(pmem_read && pmem_write), 128'(0));
                check("mem_resp_during_pmem", 128'(mem_resp), 128'(0));
                if (hold == 0) begin
                    held_addr  = pmem_address;
                    held_wdata = pmem_wdata;
                    held_rd    = pmem_read;
                end else begin
                    check("pmem_addr_stable", 128'(pmem_address), 128'(held_addr));
                    check("pmem_read_stable", 128'(pmem_read), 128'(held_rd));
                    if (pmem_write) check("pmem_wdata_stable", pmem_wdata, held_wdata);
                end
                hold++;
                if (hold > resp_delay) begin
                    if (pmem_write) begin
                        pmem_mem[int'(pmem_address)] = pmem_wdata;
                        wb_cnt++;
                        last_wb_addr = pmem_address;
                        last_wb_data = pmem_wdata;
                    end else begin
                        pmem_rdata = pmem_mem.exists(int'(pmem_address)) ?
                                     pmem_mem[int'(pmem_address)] : base_line(int'(pmem_address));
                        fill_cnt++;
                        last_fill_addr = pmem_address;
                    end
                    last_hold = hold;
                    pmem_resp = 1'b1;
                end
            end
        end
    end

    // Monitor: one scoreboard entry per mem_resp pulse.
    exp_t me;
    always @(negedge clk) begin
        if (rst_n && mem_resp) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: mem_resp=1, required 0 with nothing pending");
            end else begin
                me = sbq.pop_front();
                if (me.is_read) begin
                    check("rdata", 128'(mem_rdata), 128'(me.data));
                    last_rdata = mem_rdata;
                end
                check("fills", 128'(fill_cnt), 128'(me.fills));
                check("writebacks", 128'(wb_cnt), 128'(me.wbs));
                if (me.hit) check("hit_latency", 128'(cyc - me.issue_cyc), 128'(1));
                $display("txn %s addr=%h rdata=%h exp=%h hit=%0d fills=%0d wbs=%0d",
                         me.is_read ? "RD" : "WR", me.addr, mem_rdata, me.data,
                         me.hit, fill_cnt, wb_cnt);
            end
            fill_cnt = 0;
            wb_cnt   = 0;
        end
    end

    initial begin
        logic [127:0] pre;
        bit           got;
        int           op;
        int           tg;
        int           st;
        int           wi;
        logic [15:0]  a;

        rst_n           = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = 2'b00;
        mem_address     = 16'h0000;
        mem_wdata       = 16'h0000;
        for (int s = 0; s < 8; s++) begin
            res_valid[s] = 1'b0;
            res_dirty[s] = 1'b0;
            res_tag[s]   = 0;
        end
        pre = base_line(32'h40);
        pre[15:0]  = 16'h1234;
        pre[31:16] = 16'h5678;
        base_mem[32'h40] = pre;

        repeat (3) @(negedge clk);
        check("rst_mem_resp", 128'(mem_resp), 128'(0));
        check("rst_mem_rdata", 128'(mem_rdata), 128'(0));
        check("rst_pmem_read", 128'(pmem_read), 128'(0));
        check("rst_pmem_write", 128'(pmem_write), 128'(0));
        check("rst_pmem_address", 128'(pmem_address), 128'(0));
        check("rst_pmem_wdata", pmem_wdata, 128'(0));
`ifdef CACHE_PERF_COUNTERS_EN
        check("rst_hit_count", 128'(hit_count), 128'(0));
        check("rst_miss_count", 128'(miss_count), 128'(0));
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Cold read, then a repeat read that must hit.
        do_txn(1'b1, 1'b0, 2'b00, 16'h0040, 16'h0000);
        check("first_fill_addr", 128'(last_fill_addr), 128'(16'h0040));
        check("first_rdata", 128'(last_rdata), 128'(16'h1234));
        do_txn(1'b1, 1'b0, 2'b00, 16'h0040, 16'h0000);

        // Low-byte write, then read back the merged word.
        do_txn(1'b0, 1'b1, 2'b01, 16'h0042, 16'hBEEF);
        do_txn(1'b1, 1'b0, 2'b00, 16'h0042, 16'h0000);
        check("merged_rdata", 128'(last_rdata), 128'(16'h56EF));

        // Read with the same index and another tag: writeback of the dirty line, then a fill.
        do_txn(1'b1, 1'b0, 2'b00, 16'h0440, 16'h0000);
        check("wb_addr", 128'(last_wb_addr), 128'(16'h0040));
        check("wb_word1", 128'(last_wb_data[31:16]), 128'(16'h56EF));
        check("wb_word0", 128'(last_wb_data[15:0]), 128'(16'h1234));
        check("second_fill_addr", 128'(last_fill_addr), 128'(16'h0440));

        // Slow fill: the request must be held while memory stalls.
        resp_delay = 10;
        do_txn(1'b1, 1'b0, 2'b00, 16'h0850, 16'h0000);
        check("fill_hold_cycles", 128'(last_hold), 128'(11));

        // Random traffic over a few tags so that sets conflict.
        for (int n = 0; n < 250; n++) begin
            resp_delay = $urandom_range(0, 3);
            op = $urandom_range(0, 2);
            tg = $urandom_range(0, 3);
            st = $urandom_range(0, 7);
            wi = $urandom_range(0, 7);
            a  = 16'((tg << 7) | (st << 4) | (wi << 1) | $urandom_range(0, 1));
            do_txn(op != 1, op != 0, 2'($urandom_range(0, 3)), a, 16'($urandom));
        end
`ifdef CACHE_PERF_COUNTERS_EN
        check("rand_hit_count", 128'(hit_count), 128'(model_hits));
        check("rand_miss_count", 128'(miss_count), 128'(model_misses));
`endif

        // Reset during a writeback.
        resp_delay = 2;
        do_txn(1'b0, 1'b1, 2'b11, 16'h0440, 16'hCAFE);
        resp_delay = 20;
        mem_read    = 1'b1;
        mem_write   = 1'b0;
        mem_address = 16'h0040;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (pmem_write) begin
                got = 1'b1;
                break;
            end
        end
        check("wb_started", 128'(got), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        check("midrst_pmem_write", 128'(pmem_write), 128'(0));
        check("midrst_pmem_read", 128'(pmem_read), 128'(0));
        check("midrst_pmem_address", 128'(pmem_address), 128'(0));
        check("midrst_pmem_wdata", pmem_wdata, 128'(0));
        check("midrst_mem_resp", 128'(mem_resp), 128'(0));
        mem_read = 1'b0;
        shadow.delete();
        foreach (committed[k]) shadow[k] = committed[k];
        for (int s = 0; s < 8; s++) begin
            res_valid[s] = 1'b0;
            res_dirty[s] = 1'b0;
        end
        model_hits     = 0;
        model_misses   = 0;
        last_fill_addr = 16'hFFFF;
        @(negedge clk);
        @(negedge clk);
        fill_cnt = 0;
        wb_cnt   = 0;
        #2 rst_n = 1'b1;
        @(negedge clk);
        resp_delay = 2;
        do_txn(1'b1, 1'b0, 2'b00, 16'h0440, 16'h0000);
        check("refill_after_rst", 128'(last_fill_addr), 128'(16'h0440));
        do_txn(1'b1, 1'b0, 2'b00, 16'h0440, 16'h0000);
        do_txn(1'b1, 1'b0, 2'b00, 16'h0442, 16'h0000);
`ifdef CACHE_PERF_COUNTERS_EN
        check("post_rst_hit_count", 128'(hit_count), 128'(3));
        check("post_rst_miss_count", 128'(miss_count), 128'(1));
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 128'(sbq.size()), 128'(0));
        print_summary();
        $finish;
    end

endmodule
